// File: rtl/block_ram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between NUM_REQ requesters, with burst ownership.
// Define BRAM_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module block_ram_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 2**16,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int IW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*AW-1:0]         req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [AW-1:0]                 ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_data,
  output logic                          ram_wr_en,
  output logic                          ram_rd_en,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  // Handshake: a beat moves when req_valid[i] & req_ready[i]; ready never waits on anything but selection.
  logic [IW-1:0]          owner;
  logic                   owner_vld;
  logic [BW-1:0]          beat_cnt;
  logic [IW-1:0]          start;
  logic                   exhausted;
  logic                   cont;
  logic [NUM_REQ-1:0]     cand;
  logic [NUM_REQ-1:0]     rot;
  logic                   found;
  logic [IW-1:0]          off;
  logic [IW:0]            j;
  logic [IW-1:0]          sel;
  logic                   sel_vld;
  logic                   accept;
  logic [READ_LATENCY:0]  tag_vld;
  logic [IW-1:0]          tag_idx [0:READ_LATENCY];

`ifdef BRAM_ARB_FIXED_PRIORITY_EN
  assign start = '0;
`else
  logic [IW-1:0] rr_ptr;
  assign start = rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && !cont) begin
      rr_ptr <= (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end
`endif

  // An exhausted owner is masked out of the search and only falls back in when nobody else wants the port.
  always_comb begin
    exhausted = owner_vld && (beat_cnt >= MAX_B);
    cont      = owner_vld && req_valid[owner] && (beat_cnt < MAX_B);
    cand      = req_valid;
    if (exhausted) cand[owner] = 1'b0;
    rot   = '0;
    j     = '0;
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = {1'b0, start} + (IW+1)'(k);
      if (j >= (IW+1)'(NUM_REQ)) j = j - (IW+1)'(NUM_REQ);
      rot[k] = cand[j[IW-1:0]];
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
    j = {1'b0, start} + {1'b0, off};
    if (j >= (IW+1)'(NUM_REQ)) j = j - (IW+1)'(NUM_REQ);
    sel_vld = 1'b0;
    sel     = '0;
    if (cont) begin
      sel_vld = 1'b1;
      sel     = owner;
    end else if (found) begin
      sel_vld = 1'b1;
      sel     = j[IW-1:0];
    end else if (exhausted && req_valid[owner]) begin
      sel_vld = 1'b1;
      sel     = owner;
    end
    accept    = sel_vld && !rst;
    req_ready = accept ? (NUM_REQ'(1) << sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= '0;
      owner_vld   <= 1'b0;
      beat_cnt    <= '0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      ram_wr_en   <= 1'b0;
      ram_rd_en   <= 1'b0;
    end else begin
      ram_wr_en <= accept && req_wr[sel];
      ram_rd_en <= accept && !req_wr[sel];
      if (accept) begin
        ram_addr    <= req_addr[sel*AW +: AW];
        ram_wr_data <= req_wr_data[sel*DATA_WIDTH +: DATA_WIDTH];
        if (cont) begin
          beat_cnt <= beat_cnt + 1'b1;
        end else begin
          owner     <= sel;
          owner_vld <= 1'b1;
          beat_cnt  <= BW'(1);
        end
      end else begin
        owner_vld <= 1'b0;
        beat_cnt  <= '0;
      end
    end
  end

  // Stage 0 travels with the RAM command; stage READ_LATENCY lines up with ram_rd_data.
  always_ff @(posedge clk) begin
    if (rst) tag_vld <= '0;
    else     tag_vld <= {tag_vld[READ_LATENCY-1:0], accept && !req_wr[sel]};
  end

  always_ff @(posedge clk) begin
    tag_idx[0] <= sel;
    for (int k = 1; k <= READ_LATENCY; k++) tag_idx[k] <= tag_idx[k-1];
  end

  assign rsp_valid = (tag_vld[READ_LATENCY] && !rst) ? (NUM_REQ'(1) << tag_idx[READ_LATENCY]) : '0;
  assign rsp_data  = ram_rd_data;

endmodule
